// File: rtl/bus_arbiter.sv
// Fixed-priority bus arbiter: the lowest-index enabled source drives a registered bus,
// with contention detection, a sticky contention flag and a saturating contention counter.
module bus_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NSRC      = 8,
  parameter int HOLD_LAST = 1,
  localparam int IW       = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC-1:0]       oe_n,
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      dout,
  output logic [IW-1:0]         drv_idx,
  output logic                  drv_valid,
  output logic                  contend,
  output logic                  contend_sticky,
  output logic [7:0]            contend_cnt
);

  function automatic int unsigned count_ones(input logic [NSRC-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < NSRC; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  logic [NSRC-1:0]  req_s;
  logic             any_s;
  logic             multi_s;
  logic [IW-1:0]    win_s;
  logic [WIDTH-1:0] win_data_s;

  logic [WIDTH-1:0] dout_d, dout_q;
  logic [IW-1:0]    drv_idx_d, drv_idx_q;
  logic             drv_valid_d, drv_valid_q;
  logic             contend_d, contend_q;
  logic             sticky_d, sticky_q;
  logic [7:0]       cnt_d, cnt_q;

  // Winner selection: scanning high-to-low leaves the lowest requesting index.
  always_comb begin
    req_s      = ~oe_n;
    any_s      = |req_s;
    multi_s    = (count_ones(req_s) >= 32'd2);
    win_s      = '0;
    win_data_s = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      win_s      = req_s[i] ? IW'(i) : win_s;
      win_data_s = req_s[i] ? src[i*WIDTH +: WIDTH] : win_data_s;
    end
  end

  // Next-state for bus value, driver index and contention status.
  always_comb begin
    dout_d      = dout_q;
    drv_idx_d   = drv_idx_q;
    drv_valid_d = 1'b0;
    contend_d   = multi_s;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    if (any_s) begin
      dout_d      = win_data_s;
      drv_idx_d   = win_s;
      drv_valid_d = 1'b1;
    end else if (HOLD_LAST == 0) begin
      dout_d = '0;
    end else begin
      dout_d = dout_q;
    end

    // Contention in the same cycle as clear_err restarts the count at one.
    if (multi_s) begin
      sticky_d = 1'b1;
      if (clear_err) begin
        cnt_d = 8'd1;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (clear_err) begin
      sticky_d = 1'b0;
      cnt_d    = 8'd0;
    end else begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= '0;
      drv_idx_q   <= '0;
      drv_valid_q <= 1'b0;
      contend_q   <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      dout_q      <= dout_d;
      drv_idx_q   <= drv_idx_d;
      drv_valid_q <= drv_valid_d;
      contend_q   <= contend_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dout           = dout_q;
  assign drv_idx        = drv_idx_q;
  assign drv_valid      = drv_valid_q;
  assign contend        = contend_q;
  assign contend_sticky = sticky_q;
  assign contend_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed spec scenarios plus randomized traffic
// compared against a behavioural reference model; covers keeper, zeroing and 16x5 builds.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  oe_n;
  logic [63:0] src;
  logic        clear_err;

  logic [7:0]  dout, dout0;
  logic [2:0]  drv_idx, drv_idx0;
  logic        drv_valid, drv_valid0, contend, contend0, sticky, sticky0;
  logic [7:0]  cnt, cnt0;

  logic [4:0]  oe_n_w;
  logic [79:0] src_w;
  logic [15:0] dout_w;
  logic [2:0]  drv_idx_w;
  logic        drv_valid_w, contend_w, sticky_w;
  logic [7:0]  cnt_w;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  e_dout, e_dout0, e_cnt;
  logic [2:0]  e_idx;
  logic        e_valid, e_cont, e_sticky;
  logic [15:0] e_dout_w;
  logic [2:0]  e_idx_w;
  logic        e_valid_w;

  bus_arbiter dut (
    .clk(clk), .rst(rst), .oe_n(oe_n), .src(src), .clear_err(clear_err),
    .dout(dout), .drv_idx(drv_idx), .drv_valid(drv_valid), .contend(contend),
    .contend_sticky(sticky), .contend_cnt(cnt)
  );

  bus_arbiter #(.HOLD_LAST(0)) dut_h0 (
    .clk(clk), .rst(rst), .oe_n(oe_n), .src(src), .clear_err(clear_err),
    .dout(dout0), .drv_idx(drv_idx0), .drv_valid(drv_valid0), .contend(contend0),
    .contend_sticky(sticky0), .contend_cnt(cnt0)
  );

  bus_arbiter #(.WIDTH(16), .NSRC(5)) dut_w (
    .clk(clk), .rst(rst), .oe_n(oe_n_w), .src(src_w), .clear_err(clear_err),
    .dout(dout_w), .drv_idx(drv_idx_w), .drv_valid(drv_valid_w), .contend(contend_w),
    .contend_sticky(sticky_w), .contend_cnt(cnt_w)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    e_dout = 8'h00; e_dout0 = 8'h00; e_cnt = 8'h00; e_idx = 3'd0;
    e_valid = 1'b0; e_cont = 1'b0; e_sticky = 1'b0;
    e_dout_w = 16'h0000; e_idx_w = 3'd0; e_valid_w = 1'b0;
  endtask

  // Reference: winner = first requesting index counting up; contention = two or more requests.
  task automatic model_cycle();
    int w;
    int n;
    w = -1;
    n = $countones(~oe_n);
    for (int i = 0; i < 8; i++) if (!oe_n[i] && w < 0) w = i;
    if (n > 0) begin
      e_dout = src[w*8 +: 8]; e_dout0 = e_dout; e_idx = 3'(w); e_valid = 1'b1;
    end else begin
      e_dout0 = 8'h00; e_valid = 1'b0;
    end
    e_cont = (n >= 2);
    if (n >= 2) begin
      e_sticky = 1'b1;
      if (clear_err) e_cnt = 8'd1;
      else if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
    end else if (clear_err) begin
      e_sticky = 1'b0; e_cnt = 8'd0;
    end
    w = -1;
    for (int i = 0; i < 5; i++) if (!oe_n_w[i] && w < 0) w = i;
    if (w >= 0) begin
      e_dout_w = src_w[w*16 +: 16]; e_idx_w = 3'(w); e_valid_w = 1'b1;
    end else begin
      e_valid_w = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_cycle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; oe_n = 8'hFF; src = 64'd0; clear_err = 1'b0;
    oe_n_w = 5'h1F; src_w = 80'd0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if (drv_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", drv_idx); end
    n_cmp++; if (drv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", drv_valid); end
    n_cmp++; if (contend !== 1'b0) begin n_fail++; $display("FAIL reset_contend: got %b want 0", contend); end
    n_cmp++; if (sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", sticky); end
    n_cmp++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    oe_n = 8'h00; src = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if ({dout, drv_valid, cnt} !== 17'd0) begin n_fail++; $display("FAIL reset_held: got %h want 0", {dout, drv_valid, cnt}); end
    oe_n = 8'hFF; src = 64'd0;
    #3 rst = 1'b0;
  endtask

  task automatic test_single();
    oe_n = 8'hFB; src = 64'd0; src[2*8 +: 8] = 8'h5A;
    tick();
    n_cmp++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL single_dout: got %h want 5a", dout); end
    n_cmp++; if (drv_idx !== 3'd2) begin n_fail++; $display("FAIL single_idx: got %0d want 2", drv_idx); end
    n_cmp++; if (drv_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", drv_valid); end
    n_cmp++; if (contend !== 1'b0) begin n_fail++; $display("FAIL single_contend: got %b want 0", contend); end
    n_cmp++; if (dout0 !== 8'h5A) begin n_fail++; $display("FAIL single_dout_h0: got %h want 5a", dout0); end
  endtask

  task automatic test_idle();
    oe_n = 8'hFF; src = 64'hDEAD_BEEF_0123_4567;
    tick();
    n_cmp++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL idle_keep: got %h want 5a", dout); end
    n_cmp++; if (drv_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", drv_valid); end
    n_cmp++; if (drv_idx !== 3'd2) begin n_fail++; $display("FAIL idle_idx: got %0d want 2", drv_idx); end
    n_cmp++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL idle_zero_h0: got %h want 00", dout0); end
    n_cmp++; if (drv_idx0 !== 3'd2) begin n_fail++; $display("FAIL idle_idx_h0: got %0d want 2", drv_idx0); end
  endtask

  task automatic test_contention();
    oe_n = 8'hF5; src = 64'd0; src[1*8 +: 8] = 8'h11; src[3*8 +: 8] = 8'h33;
    tick();
    n_cmp++; if (dout !== 8'h11) begin n_fail++; $display("FAIL cont_dout: got %h want 11", dout); end
    n_cmp++; if (drv_idx !== 3'd1) begin n_fail++; $display("FAIL cont_idx: got %0d want 1", drv_idx); end
    n_cmp++; if (contend !== 1'b1) begin n_fail++; $display("FAIL cont_pulse: got %b want 1", contend); end
    n_cmp++; if (sticky !== 1'b1) begin n_fail++; $display("FAIL cont_sticky: got %b want 1", sticky); end
    n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL cont_cnt: got %0d want 1", cnt); end
    oe_n = 8'hFF;
    tick();
    n_cmp++; if (contend !== 1'b0) begin n_fail++; $display("FAIL cont_pulse_end: got %b want 0", contend); end
    n_cmp++; if (sticky !== 1'b1) begin n_fail++; $display("FAIL cont_sticky_hold: got %b want 1", sticky); end
  endtask

  task automatic test_saturation();
    oe_n = 8'h00; src = 64'h8877_6655_4433_22A1; clear_err = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    n_cmp++; if (cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", cnt); end
    n_cmp++; if (dout !== 8'hA1) begin n_fail++; $display("FAIL sat_dout: got %h want a1", dout); end
    clear_err = 1'b1;
    tick();
    n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL clr_cont_cnt: got %0d want 1", cnt); end
    n_cmp++; if (sticky !== 1'b1) begin n_fail++; $display("FAIL clr_cont_sticky: got %b want 1", sticky); end
    oe_n = 8'hFE;
    tick();
    n_cmp++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", cnt); end
    n_cmp++; if (sticky !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %b want 0", sticky); end
    n_cmp++; if (contend !== 1'b0 || drv_valid !== 1'b1) begin n_fail++; $display("FAIL clr_side: got %b%b want 01", contend, drv_valid); end
    clear_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    oe_n = 8'hF3; src = 64'd0; src[2*8 +: 8] = 8'h5A; src[3*8 +: 8] = 8'h33;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (cnt !== 8'd7 || dout !== 8'h5A) begin n_fail++; $display("FAIL pre_rst: got %0d/%h want 7/5a", cnt, dout); end
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if ({dout, drv_idx, drv_valid, contend, sticky, cnt} !== 22'd0) begin
      n_fail++; $display("FAIL mid_rst_zero: got %h want 0", {dout, drv_idx, drv_valid, contend, sticky, cnt});
    end
    oe_n = 8'h7F; src = 64'd0; src[7*8 +: 8] = 8'hC3;
    #2 rst = 1'b0;
    tick();
    n_cmp++; if (dout !== 8'hC3) begin n_fail++; $display("FAIL post_rst_dout: got %h want c3", dout); end
    n_cmp++; if (drv_idx !== 3'd7) begin n_fail++; $display("FAIL post_rst_idx: got %0d want 7", drv_idx); end
  endtask

  task automatic test_random();
    int sel;
    for (int c = 0; c < 400; c++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: oe_n = 8'hFF;
        1: oe_n = ~(8'd1 << $urandom_range(0, 7));
        2: oe_n = 8'($urandom);
        default: oe_n = ~((8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7)));
      endcase
      src = {$urandom, $urandom};
      clear_err = ($urandom_range(0, 7) == 0);
      tick();
      n_cmp++; if (dout !== e_dout) begin n_fail++; $display("FAIL rnd_dout: got %h want %h", dout, e_dout); end
      n_cmp++; if (drv_idx !== e_idx) begin n_fail++; $display("FAIL rnd_idx: got %0d want %0d", drv_idx, e_idx); end
      n_cmp++; if (drv_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid: got %b want %b", drv_valid, e_valid); end
      n_cmp++; if (contend !== e_cont) begin n_fail++; $display("FAIL rnd_contend: got %b want %b", contend, e_cont); end
      n_cmp++; if (sticky !== e_sticky) begin n_fail++; $display("FAIL rnd_sticky: got %b want %b", sticky, e_sticky); end
      n_cmp++; if (cnt !== e_cnt) begin n_fail++; $display("FAIL rnd_cnt: got %0d want %0d", cnt, e_cnt); end
      n_cmp++; if (dout0 !== e_dout0) begin n_fail++; $display("FAIL rnd_dout_h0: got %h want %h", dout0, e_dout0); end
    end
    clear_err = 1'b0;
  endtask

  task automatic test_width();
    oe_n_w = 5'b01111; src_w = 80'd0; src_w[4*16 +: 16] = 16'hBEEF;
    tick();
    n_cmp++; if (dout_w !== 16'hBEEF) begin n_fail++; $display("FAIL w_dout: got %h want beef", dout_w); end
    n_cmp++; if (drv_idx_w !== 3'd4) begin n_fail++; $display("FAIL w_idx: got %0d want 4", drv_idx_w); end
    for (int c = 0; c < 200; c++) begin
      oe_n_w = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
      src_w = {16'($urandom), $urandom, $urandom};
      tick();
      n_cmp++; if (drv_idx_w > 3'd4) begin n_fail++; $display("FAIL w_idx_range: got %0d want <=4", drv_idx_w); end
      n_cmp++; if (drv_idx_w !== e_idx_w) begin n_fail++; $display("FAIL w_rnd_idx: got %0d want %0d", drv_idx_w, e_idx_w); end
      n_cmp++; if (dout_w !== e_dout_w) begin n_fail++; $display("FAIL w_rnd_dout: got %h want %h", dout_w, e_dout_w); end
      n_cmp++; if (drv_valid_w !== e_valid_w) begin n_fail++; $display("FAIL w_rnd_valid: got %b want %b", drv_valid_w, e_valid_w); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle();
    test_contention();
    test_saturation();
    test_reset_mid();
    test_random();
    test_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, the data bus width in bits, legal range 1..32.
REQ-002 Parameter NSRC, default 8, the number of bus sources, legal range 2..16.
REQ-003 Parameter HOLD_LAST, default 1: 1 = bus keeper (holds last value when idle), 0 = idle bus reads 0.
REQ-004 Derived IW = $clog2(NSRC), the width of the driver index.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 oe_n  input  NSRC  active-low output enables; bit i requests that source i drive the bus.
REQ-008 src  input  NSRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-009 clear_err  input  1  synchronous clear of the contention status.
REQ-010 dout  output  WIDTH  registered bus value.
REQ-011 drv_idx  output  IW  registered index of the source that last drove the bus.
REQ-012 drv_valid  output  1  registered; 1 when a source drove the bus in the previous cycle.
REQ-013 contend  output  1  registered one-cycle pulse; 2 or more enables were active in the previous cycle.
REQ-014 contend_sticky  output  1  set by any contention; held until clear_err or reset.
REQ-015 contend_cnt  output  8  saturating count of cycles with contention.

Function
REQ-016 Arbitration shall be fixed priority: the lowest index i with oe_n[i]=0 wins (index 0 highest).
REQ-017 With at least one enable active, the next edge shall load dout<=src[win], drv_idx<=win, drv_valid<=1. Latency is exactly 1 cycle.
REQ-018 With no enable active and HOLD_LAST=1, dout shall hold its value, drv_idx shall hold, and drv_valid<=0.
REQ-019 With no enable active and HOLD_LAST=0, dout<=0, drv_idx shall hold, and drv_valid<=0.
REQ-020 Contention means popcount(~oe_n) >= 2 in a cycle. The winner still drives per REQ-016; contend<=1 for exactly that following cycle, otherwise contend<=0.
REQ-021 On a contention cycle, contend_sticky<=1 and contend_cnt<=contend_cnt+1, saturating at 255 (no wrap).
REQ-022 clear_err=1 without contention in the same cycle: contend_sticky<=0 and contend_cnt<=0.
REQ-023 clear_err=1 together with contention in the same cycle: contention wins, so contend_sticky<=1 and contend_cnt<=1.
REQ-024 clear_err shall not affect dout, drv_idx, drv_valid or contend.
REQ-025 Source data of non-winning sources shall never reach dout, including during contention.
REQ-026 Output changes shall depend only on sampled inputs; there is no combinational path from inputs to outputs.
REQ-027 For NSRC not a power of two, indices >= NSRC do not exist and shall never appear on drv_idx.

Reset
REQ-028 While rst=1, all outputs shall be 0 immediately (asynchronously): dout=0, drv_idx=0, drv_valid=0, contend=0, contend_sticky=0, contend_cnt=0.
REQ-029 Reset asserted mid-operation shall discard any pending load and the contention status. The first edge after rst falls performs a normal arbitration cycle.
REQ-030 Reset release need not be synchronised inside this block; release synchronisation is the integrator's responsibility.

Verification
REQ-031 Defaults, oe_n=8'hFB (source 2 only), src[2]=8'h5A -> after 1 edge: dout=8'h5A, drv_idx=2, drv_valid=1, contend=0.
REQ-032 oe_n=8'hF5 (sources 1 and 3), src[1]=8'h11, src[3]=8'h33 -> dout=8'h11, drv_idx=1, contend=1 for one cycle, contend_sticky=1, contend_cnt=1.
REQ-033 Idle behaviour: after dout=8'h5A, set oe_n=8'hFF -> HOLD_LAST=1: dout stays 8'h5A, drv_valid=0; HOLD_LAST=0 build: dout=0.
REQ-034 Counter saturation and clear: hold oe_n=8'h00 for 300 cycles -> contend_cnt=255. Then clear_err=1 with oe_n=8'h00 -> contend_cnt=1, contend_sticky=1. Then clear_err=1 with oe_n=8'hFE -> contend_cnt=0, contend_sticky=0.
REQ-035 Assert rst between clock edges while dout=8'h5A and contend_cnt=7 -> all outputs 0 before the next edge. Release with oe_n=8'h7F and src[7]=8'hC3 -> one edge later dout=8'hC3, drv_idx=7.
REQ-036 Width check: WIDTH=16, NSRC=5, source 4 only, src[4]=16'hBEEF -> dout=16'hBEEF, drv_idx=3'd4. No index value above 4 ever appears on drv_idx.
